icache_refill_master: RTL and testbench
=======================================

Name: icache_refill_master

Overview:
- Initiator side of the icache memory interface.
- Accepts one fetch-miss request at a time from the icache controller and issues an icache_req_t to memory using the req/ack handshake.
- Waits for the matching ICACHE_IFILL_ACK and returns the full line to the controller.
- Forwards ICACHE_INV_REQ returns to the controller as invalidation pulses, and flags a refill that an invalidation hits while it is in flight.

Parameters:
- TidWidth, 2, width of the transaction id field used in this block; the id counter wraps modulo 2^TidWidth.
- TimeoutCycles, 1024, maximum cycles allowed in WAIT before a timeout error (only with the optional feature).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- miss_req_i  in  1  client miss request
- miss_paddr_i  in  64  miss physical address
- miss_nc_i  in  1  non-cacheable access
- miss_way_i  in  ICACHE_SET_ASSOC  one-hot victim way
- miss_gnt_o  out  1  request accepted this cycle
- line_vld_o  out  1  one-cycle line return pulse
- line_data_o  out  ICACHE_LINE_WIDTH  returned line
- line_paddr_o  out  64  address of the returned line
- line_noalloc_o  out  1  client must not allocate this line
- inv_vld_o  out  1  one-cycle invalidation pulse
- inv_idx_o  out  ICACHE_INDEX_WIDTH  invalidation index
- inv_all_o  out  1  invalidate all ways
- mem_data_req_o  out  1  memory request valid
- mem_data_ack_i  in  1  memory request accepted
- mem_data_o  out  icache_req_t  request payload (paddr, nc, way, tid)
- mem_rtrn_vld_i  in  1  memory return valid
- mem_rtrn_i  in  icache_rtrn_t  return payload
- err_unexp_o  out  1  unexpected or mismatched fill ack, one-cycle pulse
- err_timeout_o  out  1  sticky timeout flag

Behaviour:
- Reset: state IDLE; all outputs 0; tid counter 0; kill flag 0.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - miss_gnt_o = miss_req_i, combinational.
  - On grant: register paddr, nc, way and the current tid; go to REQ.
- Request address:
  - Cacheable: paddr with the low log2(ICACHE_LINE_WIDTH/8) bits cleared.
  - Non-cacheable: paddr with bits [1:0] cleared.
- REQ:
  - mem_data_req_o = 1; mem_data_o is held stable until mem_data_ack_i.
  - Same cycle as ack: go to WAIT and increment tid (wraps modulo 2^TidWidth).
- WAIT: on mem_rtrn_vld_i with rtype ICACHE_IFILL_ACK and tid equal to the stored tid:
  - Next cycle: line_vld_o = 1 for one cycle; line_data_o = data; line_paddr_o = stored request address; line_noalloc_o = nc | kill flag.
  - Then clear the kill flag and go to IDLE.
- Minimum miss-to-line latency: grant in cycle 0, req in cycle 1 with ack, return in cycle 2, line_vld_o in cycle 3.
- An ICACHE_IFILL_ACK in IDLE or REQ, or one with a mismatched tid, is dropped and err_unexp_o pulses the next cycle. State is unchanged.
- ICACHE_INV_REQ in any state:
  - Next cycle: inv_vld_o = 1 for one cycle, with inv_idx_o and inv_all_o taken from the payload.
  - If state is REQ or WAIT and inv idx equals the stored address index bits, set the kill flag.
  - A kill-flag set and a fill ack in the same cycle: line_noalloc_o = 1.
- mem_rtrn_vld_i carries at most one return per cycle, so an invalidation and a fill never coincide.
- Reset mid-transaction returns to IDLE at once with no line pulse. Any later return is treated as unexpected.

Optional Feature:
- Macro: ICACHE_REFILL_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on entry to WAIT and increments each cycle in WAIT.
  - Reaching TimeoutCycles sets err_timeout_o (sticky until reset), returns to IDLE, and emits no line.
  - A late fill ack for that tid then raises err_unexp_o.
- Without the macro: no counter; err_timeout_o is tied to 0 and WAIT persists indefinitely.

Test Plan:
- Cacheable miss paddr=0x8000_1234, ack immediate, fill ack tid=0, data pattern A → mem_data_o.paddr=0x8000_1230 (for a 16B line), line_vld_o at cycle 3, line_paddr_o=0x8000_1230, line_noalloc_o=0.
- Non-cacheable miss paddr=0x0000_0106, ack delayed 5 cycles → mem_data_o is stable for 5 cycles with paddr=0x104 and nc=1; line_noalloc_o=1.
- During WAIT, an INV_REQ with idx equal to the pending index, all=1, then the fill ack → inv_vld_o pulse, then line_vld_o with line_noalloc_o=1.
- A fill ack in IDLE, and a fill ack in WAIT with tid=1 while expecting 0 → err_unexp_o pulses twice; no line_vld_o; still in WAIT.
- Five back-to-back misses → tids 0,1,2,3,0 (wrap); five line pulses in order.
- With ICACHE_REFILL_TIMEOUT_EN defined and TimeoutCycles=16, no return → err_timeout_o=1 after 16 WAIT cycles; miss_gnt_o available again.

Source files
------------

// File: rtl/icache_refill_master_if.sv
// Shared icache memory-interface types plus the request/return bundle.
// icache_pkg: line/index geometry, request payload and return payload types.
// icache_refill_master_if: req/ack request channel and valid-only return channel.
package icache_pkg;
  localparam int ICACHE_SET_ASSOC    = 4;
  localparam int ICACHE_LINE_WIDTH   = 128;  // 16-byte line
  localparam int ICACHE_INDEX_WIDTH  = 12;   // byte index within a way
  localparam int ICACHE_OFFSET_WIDTH = $clog2(ICACHE_LINE_WIDTH / 8);
  localparam int ICACHE_TID_WIDTH    = 4;    // payload field; blocks may use fewer bits

  typedef enum logic [1:0] {
    ICACHE_IFILL_ACK = 2'd0,
    ICACHE_INV_REQ   = 2'd1
  } icache_in_t;

  typedef struct packed {
    logic                          all;
    logic [ICACHE_INDEX_WIDTH-1:0] idx;
  } icache_inval_t;

  typedef struct packed {
    logic [63:0]                 paddr;
    logic                        nc;
    logic [ICACHE_SET_ASSOC-1:0] way;
    logic [ICACHE_TID_WIDTH-1:0] tid;
  } icache_req_t;

  typedef struct packed {
    icache_in_t                   rtype;
    logic [ICACHE_LINE_WIDTH-1:0] data;
    icache_inval_t                inv;
    logic [ICACHE_TID_WIDTH-1:0]  tid;
  } icache_rtrn_t;
endpackage

interface icache_refill_master_if;
  import icache_pkg::*;

  logic         mem_data_req;
  logic         mem_data_ack;
  icache_req_t  mem_data;
  logic         mem_rtrn_vld;
  icache_rtrn_t mem_rtrn;

  modport master (
    output mem_data_req, mem_data,
    input  mem_data_ack, mem_rtrn_vld, mem_rtrn
  );

  modport slave (
    input  mem_data_req, mem_data,
    output mem_data_ack, mem_rtrn_vld, mem_rtrn
  );
endinterface

// File: rtl/icache_refill_master.sv
// Purpose: icache refill initiator - one miss at a time, req/ack to memory, line return to the client.
// Latency: grant -> mem request next cycle -> line_vld_o one cycle after the matching fill ack (3 cycles min).
// Backpressure: miss_gnt_o only in IDLE; mem_data_o held stable until mem_data_ack_i.
// Ports: clk_i/rst_ni; miss_* request + miss_gnt_o; line_* line return; inv_* invalidation pulse;
//        mem (icache_refill_master_if.master) memory side; err_unexp_o pulse, err_timeout_o sticky.
// Optional: ICACHE_REFILL_TIMEOUT_EN bounds WAIT to TimeoutCycles cycles and abandons the refill.
module icache_refill_master
  import icache_pkg::*;
#(
  parameter int unsigned TidWidth = 2
`ifdef ICACHE_REFILL_TIMEOUT_EN
  ,
  parameter int unsigned TimeoutCycles = 1024
`endif
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          miss_req_i,
  input  logic [63:0]                   miss_paddr_i,
  input  logic                          miss_nc_i,
  input  logic [ICACHE_SET_ASSOC-1:0]   miss_way_i,
  output logic                          miss_gnt_o,
  output logic                          line_vld_o,
  output logic [ICACHE_LINE_WIDTH-1:0]  line_data_o,
  output logic [63:0]                   line_paddr_o,
  output logic                          line_noalloc_o,
  output logic                          inv_vld_o,
  output logic [ICACHE_INDEX_WIDTH-1:0] inv_idx_o,
  output logic                          inv_all_o,
  icache_refill_master_if.master        mem,
  output logic                          err_unexp_o,
  output logic                          err_timeout_o
);

  localparam int OffW = ICACHE_OFFSET_WIDTH;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  state_e                        state_q, state_d;
  icache_req_t                   req_q, req_d;
  logic [TidWidth-1:0]           tid_cnt_q, tid_cnt_d;
  logic                          kill_q, kill_d;
  logic                          line_vld_q, line_vld_d;
  logic [ICACHE_LINE_WIDTH-1:0]  line_data_q, line_data_d;
  logic [63:0]                   line_paddr_q, line_paddr_d;
  logic                          line_noalloc_q, line_noalloc_d;
  logic                          inv_vld_q, inv_vld_d;
  logic [ICACHE_INDEX_WIDTH-1:0] inv_idx_q, inv_idx_d;
  logic                          inv_all_q, inv_all_d;
  logic                          err_unexp_q, err_unexp_d;

  logic rtrn_fill, rtrn_inv, fill_hit, inv_hit;

  // Non-cacheable fetches keep word granularity; cacheable ones are line aligned.
  function automatic logic [63:0] req_addr(input logic [63:0] pa, input logic nc);
    if (nc) return {pa[63:2], 2'b00};
    return {pa[63:OffW], {OffW{1'b0}}};
  endfunction

  assign rtrn_fill = mem.mem_rtrn_vld && (mem.mem_rtrn.rtype == ICACHE_IFILL_ACK);
  assign rtrn_inv  = mem.mem_rtrn_vld && (mem.mem_rtrn.rtype == ICACHE_INV_REQ);
  assign fill_hit  = rtrn_fill && (state_q == WAIT) && (mem.mem_rtrn.tid == req_q.tid);
  // Only the set-index bits matter: the line offset inside the index is ignored.
  assign inv_hit   = rtrn_inv && (state_q != IDLE) &&
                     (mem.mem_rtrn.inv.idx[ICACHE_INDEX_WIDTH-1:OffW] ==
                      req_q.paddr[ICACHE_INDEX_WIDTH-1:OffW]);

`ifdef ICACHE_REFILL_TIMEOUT_EN
  localparam int CntW = $clog2(TimeoutCycles + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_to_q, err_to_d;
`endif

  always_comb begin
    state_d        = state_q;
    req_d          = req_q;
    tid_cnt_d      = tid_cnt_q;
    kill_d         = kill_q | inv_hit;
    line_vld_d     = 1'b0;
    line_data_d    = line_data_q;
    line_paddr_d   = line_paddr_q;
    line_noalloc_d = line_noalloc_q;
    inv_vld_d      = rtrn_inv;
    inv_idx_d      = rtrn_inv ? mem.mem_rtrn.inv.idx : inv_idx_q;
    inv_all_d      = rtrn_inv ? mem.mem_rtrn.inv.all : inv_all_q;
    err_unexp_d    = rtrn_fill && !fill_hit;
    miss_gnt_o     = 1'b0;
`ifdef ICACHE_REFILL_TIMEOUT_EN
    cnt_d          = cnt_q;
    err_to_d       = err_to_q;
`endif

    unique case (state_q)
      IDLE: begin
        miss_gnt_o = miss_req_i;
        if (miss_req_i) begin
          req_d.paddr = req_addr(miss_paddr_i, miss_nc_i);
          req_d.nc    = miss_nc_i;
          req_d.way   = miss_way_i;
          req_d.tid   = ICACHE_TID_WIDTH'(tid_cnt_q);
          kill_d      = 1'b0;
          state_d     = REQ;
        end
      end
      REQ: begin
        if (mem.mem_data_ack) begin
          tid_cnt_d = tid_cnt_q + TidWidth'(1);
          state_d   = WAIT;
`ifdef ICACHE_REFILL_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end
      WAIT: begin
        if (fill_hit) begin
          line_vld_d     = 1'b1;
          line_data_d    = mem.mem_rtrn.data;
          line_paddr_d   = req_q.paddr;
          // inv_hit cannot coincide with a fill today; kept so a same-cycle kill still wins.
          line_noalloc_d = req_q.nc | kill_q | inv_hit;
          kill_d         = 1'b0;
          state_d        = IDLE;
        end
`ifdef ICACHE_REFILL_TIMEOUT_EN
        else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
          // Abandon the refill; a late ack for this tid is reported as unexpected.
          err_to_d = 1'b1;
          kill_d   = 1'b0;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      req_q          <= '0;
      tid_cnt_q      <= '0;
      kill_q         <= 1'b0;
      line_vld_q     <= 1'b0;
      line_data_q    <= '0;
      line_paddr_q   <= '0;
      line_noalloc_q <= 1'b0;
      inv_vld_q      <= 1'b0;
      inv_idx_q      <= '0;
      inv_all_q      <= 1'b0;
      err_unexp_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      req_q          <= req_d;
      tid_cnt_q      <= tid_cnt_d;
      kill_q         <= kill_d;
      line_vld_q     <= line_vld_d;
      line_data_q    <= line_data_d;
      line_paddr_q   <= line_paddr_d;
      line_noalloc_q <= line_noalloc_d;
      inv_vld_q      <= inv_vld_d;
      inv_idx_q      <= inv_idx_d;
      inv_all_q      <= inv_all_d;
      err_unexp_q    <= err_unexp_d;
    end
  end

`ifdef ICACHE_REFILL_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      err_to_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      err_to_q <= err_to_d;
    end
  end
  assign err_timeout_o = err_to_q;
`else
  assign err_timeout_o = 1'b0;
`endif

  assign mem.mem_data_req = (state_q == REQ);
  assign mem.mem_data     = req_q;
  assign line_vld_o       = line_vld_q;
  assign line_data_o      = line_data_q;
  assign line_paddr_o     = line_paddr_q;
  assign line_noalloc_o   = line_noalloc_q;
  assign inv_vld_o        = inv_vld_q;
  assign inv_idx_o        = inv_idx_q;
  assign inv_all_o        = inv_all_q;
  assign err_unexp_o      = err_unexp_q;

endmodule

// File: tb/tb_icache_refill_master.sv
// Testbench for icache_refill_master: directed scenarios followed by randomized misses,
// fills and invalidations, checked against a transaction-level model (tid sequence,
// aligned request address, kill-by-index rule) kept in plain variables.
`timescale 1ns/1ps
module tb_icache_refill_master;
  import icache_pkg::*;

  localparam int TIMEOUT = 16;
  localparam int LINE_B  = ICACHE_LINE_WIDTH / 8;
  localparam longint IDX_SPAN = 64'd1 << ICACHE_INDEX_WIDTH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic miss_req = 1'b0;
  logic [63:0] miss_paddr = '0;
  logic miss_nc = 1'b0;
  logic [ICACHE_SET_ASSOC-1:0] miss_way = '0;
  logic miss_gnt_o, line_vld_o, line_noalloc_o, inv_vld_o, inv_all_o, err_unexp_o, err_timeout_o;
  logic [ICACHE_LINE_WIDTH-1:0] line_data_o;
  logic [63:0] line_paddr_o;
  logic [ICACHE_INDEX_WIDTH-1:0] inv_idx_o;

  icache_refill_master_if mem_if();

  icache_refill_master #(
    .TidWidth(2)
`ifdef ICACHE_REFILL_TIMEOUT_EN
    , .TimeoutCycles(TIMEOUT)
`endif
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .miss_req_i(miss_req), .miss_paddr_i(miss_paddr), .miss_nc_i(miss_nc), .miss_way_i(miss_way),
    .miss_gnt_o(miss_gnt_o),
    .line_vld_o(line_vld_o), .line_data_o(line_data_o), .line_paddr_o(line_paddr_o),
    .line_noalloc_o(line_noalloc_o),
    .inv_vld_o(inv_vld_o), .inv_idx_o(inv_idx_o), .inv_all_o(inv_all_o),
    .mem(mem_if),
    .err_unexp_o(err_unexp_o), .err_timeout_o(err_timeout_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail = 0;

  // Reference model state
  int          exp_tid = 0;
  logic [3:0]  pend_tid;
  logic [63:0] pend_addr;
  logic        pend_nc, pend_kill;
  bit          in_flight = 0;
  int          t_grant, t_line;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model_addr(input logic [63:0] pa, input logic nc);
    if (nc) return pa & ~64'h3;
    return pa & ~64'(LINE_B - 1);
  endfunction

  function automatic bit idx_hits(input logic [ICACHE_INDEX_WIDTH-1:0] idx, input logic [63:0] a);
    return ((a % IDX_SPAN) / LINE_B) == (64'(idx) / LINE_B);
  endfunction

  task automatic clear_rtrn();
    mem_if.mem_rtrn_vld = 1'b0;
    mem_if.mem_rtrn     = '0;
  endtask

  // Grant a miss, watch the request stay stable for ack_dly cycles, then ack it.
  task automatic miss(input logic [63:0] pa, input logic nc, input logic [3:0] way, input int ack_dly);
    miss_req = 1'b1; miss_paddr = pa; miss_nc = nc; miss_way = way;
    #1 chk("miss_gnt", miss_gnt_o, 1'b1);
    t_grant = cyc;
    step();
    miss_req = 1'b0;
    pend_addr = model_addr(pa, nc); pend_nc = nc; pend_kill = 1'b0;
    pend_tid = 4'(exp_tid); in_flight = 1;
    chk("req_vld", mem_if.mem_data_req, 1'b1);
    chk("req_paddr", mem_if.mem_data.paddr, pend_addr);
    chk("req_nc", mem_if.mem_data.nc, nc);
    chk("req_way", mem_if.mem_data.way, way);
    chk("req_tid", mem_if.mem_data.tid, pend_tid);
    for (int i = 0; i < ack_dly; i++) begin
      step();
      chk("req_hold", mem_if.mem_data_req, 1'b1);
      chk("req_stable", mem_if.mem_data, {pend_addr, nc, way, pend_tid});
    end
    mem_if.mem_data_ack = 1'b1;
    step();
    mem_if.mem_data_ack = 1'b0;
    chk("req_drop", mem_if.mem_data_req, 1'b0);
    exp_tid = (exp_tid + 1) % 4;
  endtask

  task automatic fill(input logic [3:0] tid, input logic [127:0] data, input bit expect_line);
    mem_if.mem_rtrn_vld = 1'b1;
    mem_if.mem_rtrn.rtype = ICACHE_IFILL_ACK;
    mem_if.mem_rtrn.tid = tid;
    mem_if.mem_rtrn.data = data;
    step();
    clear_rtrn();
    if (expect_line) begin
      t_line = cyc;
      chk("line_vld", line_vld_o, 1'b1);
      chk("line_data", line_data_o, data);
      chk("line_paddr", line_paddr_o, pend_addr);
      chk("line_noalloc", line_noalloc_o, pend_nc | pend_kill);
      chk("err_unexp_quiet", err_unexp_o, 1'b0);
      in_flight = 0;
    end else begin
      chk("no_line", line_vld_o, 1'b0);
      chk("err_unexp", err_unexp_o, 1'b1);
    end
    step();
    chk("line_pulse_end", line_vld_o, 1'b0);
    chk("err_pulse_end", err_unexp_o, 1'b0);
  endtask

  task automatic inv(input logic [ICACHE_INDEX_WIDTH-1:0] idx, input logic all);
    mem_if.mem_rtrn_vld = 1'b1;
    mem_if.mem_rtrn.rtype = ICACHE_INV_REQ;
    mem_if.mem_rtrn.inv.idx = idx;
    mem_if.mem_rtrn.inv.all = all;
    if (in_flight && idx_hits(idx, pend_addr)) pend_kill = 1'b1;
    step();
    clear_rtrn();
    chk("inv_vld", inv_vld_o, 1'b1);
    chk("inv_idx", inv_idx_o, idx);
    chk("inv_all", inv_all_o, all);
    step();
    chk("inv_pulse_end", inv_vld_o, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] pa;
    logic [3:0]  old_tid;
    int          n;

    mem_if.mem_data_ack = 1'b0;
    clear_rtrn();

    // Reset state
    step(); step();
    chk("rst_req", mem_if.mem_data_req, 1'b0);
    chk("rst_mem_data", mem_if.mem_data, '0);
    chk("rst_line_vld", line_vld_o, 1'b0);
    chk("rst_line_data", line_data_o, '0);
    chk("rst_line_paddr", line_paddr_o, '0);
    chk("rst_inv_vld", inv_vld_o, 1'b0);
    chk("rst_err", {err_unexp_o, err_timeout_o, miss_gnt_o}, 3'b000);
    rst_n = 1'b1;
    step();

    // Cacheable miss, minimum latency
    miss(64'h8000_1234, 1'b0, 4'b0001, 0);
    fill(pend_tid, 128'hA5A5_0001_A5A5_0002_A5A5_0003_A5A5_0004, 1);
    chk("latency", 32'(t_line - t_grant), 32'd3);

    // Non-cacheable miss, delayed ack
    miss(64'h0000_0106, 1'b1, 4'b0010, 5);
    chk("nc_addr", pend_addr, 64'h104);
    fill(pend_tid, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 1);

    // Invalidation hitting the in-flight line
    miss(64'h0000_0000_4567_89A8, 1'b0, 4'b0100, 1);
    inv(pend_addr[ICACHE_INDEX_WIDTH-1:0], 1'b1);
    fill(pend_tid, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555, 1);

    // Unexpected fills: in IDLE, then with the wrong tid while waiting
    fill(4'(exp_tid), 128'h0, 0);
    miss(64'h0000_0000_0000_2040, 1'b0, 4'b1000, 0);
    fill(pend_tid ^ 4'h1, 128'hBAD, 0);
    chk("still_wait", mem_if.mem_data_req, 1'b0);
    fill(pend_tid, 128'hCAFE_F00D, 1);

    // Reset in the middle of a request
    miss_req = 1'b1; miss_paddr = 64'h3000; miss_nc = 1'b0; miss_way = 4'b0001;
    step();
    miss_req = 1'b0;
    old_tid = 4'(exp_tid);
    chk("mid_req", mem_if.mem_data_req, 1'b1);
    rst_n = 1'b0;
    #1 chk("rst_async", mem_if.mem_data_req, 1'b0);
    step();
    rst_n = 1'b1;
    exp_tid = 0; in_flight = 0;
    step();
    chk("rst_no_line", line_vld_o, 1'b0);
    fill(old_tid, 128'h5, 0);

    // Five misses: tid sequence 0,1,2,3,0
    for (int i = 0; i < 5; i++) begin
      miss(64'h9000_0000 + 64'(i * 32), 1'b0, 4'b0001, 0);
      fill(pend_tid, 128'(i + 100), 1);
    end

    // Randomized traffic
    for (int it = 0; it < 24; it++) begin
      int r;
      pa = {$urandom, $urandom};
      miss(pa, 1'($urandom_range(0, 1)), 4'(1 << $urandom_range(0, 3)), $urandom_range(0, 3));
      r = $urandom_range(0, 3);
      if (r == 0) inv(pend_addr[ICACHE_INDEX_WIDTH-1:0] ^ 12'($urandom_range(0, LINE_B - 1)), 1'($urandom));
      else if (r == 1) inv(12'($urandom), 1'($urandom));
      else if (r == 2) fill(pend_tid + 4'($urandom_range(1, 3)), 128'($urandom), 0);
      fill(pend_tid, {$urandom, $urandom, $urandom, $urandom}, 1);
    end

`ifdef ICACHE_REFILL_TIMEOUT_EN
    miss(64'h7000_0040, 1'b0, 4'b0010, 0);
    n = 0;
    for (int i = 0; i < 3 * TIMEOUT; i++) begin
      step();
      n++;
      if (err_timeout_o) break;
    end
    chk("timeout_cycles", 32'(n), 32'(TIMEOUT));
    chk("timeout_no_line", line_vld_o, 1'b0);
    miss_req = 1'b1;
    #1 chk("gnt_after_timeout", miss_gnt_o, 1'b1);
    miss_req = 1'b0;
    in_flight = 0;
    fill(pend_tid, 128'h77, 0);
    chk("timeout_sticky", err_timeout_o, 1'b1);
`else
    miss(64'h7000_0040, 1'b0, 4'b0010, 0);
    n = 0;
    for (int i = 0; i < 3 * TIMEOUT; i++) begin
      step();
      if (err_timeout_o || line_vld_o) n++;
    end
    chk("no_timeout", 32'(n), 32'd0);
    fill(pend_tid, 128'h77, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
